// File: rtl/bch_eras_syndrome_pkg.sv
// Shared types, code geometry and GF(2^m) helpers for the BCH errors-and-erasures syndrome block.
package bch_eras_syndrome_pkg;

  localparam int M      = 4;
  localparam int K_MAX  = 5;
  localparam int D      = 7;
  localparam int N      = 15;
  localparam int IRRPOL = 19;
  localparam int T      = (D - 1) / 2;
  localparam int T2     = 2 * T;

  function automatic int clogb2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  localparam int ERA_W = clogb2(T2 + 2);

  typedef logic [M-1:0]     data_t;
  typedef logic [3:0]       ptr_t;
  typedef logic [ERA_W-1:0] era_t;

  typedef enum logic {cIDLE, cFRAME} state_t;

  localparam data_t POLY = data_t'(IRRPOL);

  // Multiply by alpha (x) modulo the primitive polynomial.
  function automatic data_t gf_xtime(input data_t a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : data_t'(0));
  endfunction

  function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
    data_t p;
    data_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  function automatic data_t gf_alpha_pow(input int e);
    data_t a;
    a = data_t'(1);
    for (int i = 0; i < (e % ((1 << M) - 1)); i++) a = gf_xtime(a);
    return a;
  endfunction

endpackage

// File: rtl/bch_eras_syndrome_acc.sv
// One Horner cell: acc <= (clear ? 0 : acc * alpha^J) ^ bit, with a constant multiplier.
module bch_eras_syndrome_acc
  import bch_eras_syndrome_pkg::*;
#(
  parameter int J = 1
) (
  input  logic  iclk,
  input  logic  ireset,
  input  logic  iclkena,
  input  logic  iena,
  input  logic  iclear,
  input  logic  ibit,
  output data_t oacc_d,
  output data_t oacc
);

  localparam data_t ALPHA_J = gf_alpha_pow(J);

  data_t acc_q;
  data_t acc_d;

  always_comb begin
    acc_d = (iclear ? data_t'(0) : gf_mult_a_by_b(acc_q, ALPHA_J)) ^ {{(M-1){1'b0}}, ibit};
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)                acc_q <= '0;
    else if (iclkena && iena)  acc_q <= acc_d;
  end

  assign oacc_d = acc_d;
  assign oacc   = acc_q;

endmodule

// File: rtl/bch_eras_syndrome.sv
// Serial MSB-first syndrome generator producing erasures-as-0 and erasures-as-1 syndrome sets.
module bch_eras_syndrome
  import bch_eras_syndrome_pkg::*;
(
  input  logic   iclk,
  input  logic   ireset,
  input  logic   iclkena,
  input  logic   ival,
  input  logic   isop,
  input  logic   ieop,
  input  logic   idat,
  input  logic   iera,
  input  ptr_t   iptr,
  output logic   osyndrome_val,
  output ptr_t   osyndrome_ptr,
  output data_t  osyndrome [2][1:T2],
  output era_t   oera_num,
  output logic   oera_overflow,
  output state_t ostate
);

  // Handshake: a beat is accepted when ival is high on an iclkena cycle and
  // either starts a frame (isop) or continues one already open.
  state_t state_q, state_d;
  era_t   cnt_q, cnt_d, cnt_next;
  ptr_t   ptr_q, ptr_d;
  logic   val_q, val_d;
  ptr_t   optr_q, optr_d;
  era_t   num_q, num_d;
  logic   ovf_q, ovf_d;
  data_t  synd_q [2][1:T2];
  data_t  synd_d [2][1:T2];
  data_t  acc_d  [2][1:T2];
  data_t  acc_q  [2][1:T2];

  logic beat_ok;
  logic done;
  logic b [2];

  assign beat_ok = ival & (isop | (state_q == cFRAME));
  assign done    = beat_ok & ieop;
  assign b[0]    = idat & ~iera;
  assign b[1]    = idat | iera;

  for (genvar s = 0; s < 2; s++) begin : g_set
    for (genvar j = 1; j <= T2; j++) begin : g_pow
      bch_eras_syndrome_acc #(.J(j)) u_acc (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iena    (beat_ok),
        .iclear  (isop),
        .ibit    (b[s]),
        .oacc_d  (acc_d[s][j]),
        .oacc    (acc_q[s][j])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    if (ival) begin
      case (state_q)
        cIDLE:   if (isop && !ieop) state_d = cFRAME;
        cFRAME:  if (ieop) state_d = cIDLE;
        default: state_d = cIDLE;
      endcase
    end

    // Count saturates at T2+1: enough to flag overflow without wrapping.
    if (isop)                               cnt_next = era_t'(iera);
    else if (iera && cnt_q != era_t'(T2+1)) cnt_next = cnt_q + 1'b1;
    else                                    cnt_next = cnt_q;
    cnt_d = beat_ok ? cnt_next : cnt_q;
    ptr_d = (ival && isop) ? iptr : ptr_q;

    val_d  = done;
    optr_d = optr_q;
    num_d  = num_q;
    ovf_d  = ovf_q;
    synd_d = synd_q;
    if (done) begin
      optr_d = ptr_d;
      num_d  = cnt_next;
      ovf_d  = (cnt_next > era_t'(T2));
      synd_d = acc_d;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= cIDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      val_q   <= 1'b0;
      optr_q  <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
      for (int s = 0; s < 2; s++)
        for (int j = 1; j <= T2; j++) synd_q[s][j] <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      optr_q  <= optr_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
      synd_q  <= synd_d;
    end
  end

  assign osyndrome_val = val_q;
  assign osyndrome_ptr = optr_q;
  assign osyndrome     = synd_q;
  assign oera_num      = num_q;
  assign oera_overflow = ovf_q;
  assign ostate        = state_q;

endmodule
